// File: rtl/max_bcd_display.sv
// rtl/max_bcd_display.sv - register-mapped binary-to-BCD converter driving seven-segment displays
// Sequential double-dabble converts the written value; result is held in a digit bank for display.
module max_bcd_display #(
    parameter int DATA_W = 7,
    parameter int DIGITS = 3
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iChipselect_n,
    input  logic                  iWrite_n,
    input  logic                  iRead_n,
    input  logic [1:0]            iAddress,
    input  logic [31:0]           iData,
    output logic [31:0]           oData,
    output logic [7*DIGITS-1:0]   oHEX
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_BCD    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_UPDATE
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [DATA_W-1:0]  value;
    logic [SH_W-1:0]    shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd;
    logic               done;
    logic               overrun;
    logic               blank;
    logic               lz_suppress;
    logic               busy;

    logic               wr_en;
    logic               rd_en;
    logic               value_wr;
    logic               status_wr;
    logic               ctrl_wr;
    logic               load;
    logic               step;
    logic               commit;
    logic [31:0]        rd_mux;
    logic               unused_data_bits;

    assign wr_en     = ~iChipselect_n & ~iWrite_n;
    assign rd_en     = ~iChipselect_n & ~iRead_n;
    assign value_wr  = wr_en && (iAddress == ADDR_VALUE);
    assign status_wr = wr_en && (iAddress == ADDR_STATUS);
    assign ctrl_wr   = wr_en && (iAddress == ADDR_CTRL);
    assign busy      = (state != S_IDLE);

    assign unused_data_bits = ^iData[31:DATA_W];

    // One combined double-dabble iteration: correct every nibble >= 5, then shift left.
    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] sh);
        logic [SH_W-1:0] tmp;
        tmp = sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (tmp[DATA_W+4*i +: 4] >= 4'd5) begin
                tmp[DATA_W+4*i +: 4] = tmp[DATA_W+4*i +: 4] + 4'd3;
            end
        end
        return {tmp[SH_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (value_wr) begin
                    load       = 1'b1;
                    next_state = S_CONV;
                end
            end
            S_CONV: begin
                step = 1'b1;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                commit     = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            value     <= '0;
            shift_reg <= '0;
            cnt       <= '0;
            bcd       <= '0;
        end else begin
            if (load) begin
                value     <= iData[DATA_W-1:0];
                shift_reg <= {{BCD_W{1'b0}}, iData[DATA_W-1:0]};
                cnt       <= '0;
            end else if (step) begin
                shift_reg <= dabble_step(shift_reg);
                cnt       <= cnt + CNT_W'(1);
            end
            if (commit) begin
                bcd <= shift_reg[SH_W-1 -: BCD_W];
            end
        end
    end

    // Completion beats a same-cycle W1C so a finished result is never lost.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            done        <= 1'b0;
            overrun     <= 1'b0;
            blank       <= 1'b0;
            lz_suppress <= 1'b0;
        end else begin
            if (commit) begin
                done <= 1'b1;
            end else if (load) begin
                done <= 1'b0;
            end else if (status_wr && iData[0]) begin
                done <= 1'b0;
            end

            if (value_wr && busy) begin
                overrun <= 1'b1;
            end else if (status_wr && iData[2]) begin
                overrun <= 1'b0;
            end

            if (ctrl_wr) begin
                blank       <= iData[0];
                lz_suppress <= iData[1];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (iAddress)
            ADDR_VALUE:  rd_mux = 32'(value);
            ADDR_BCD:    rd_mux = 32'(bcd);
            ADDR_STATUS: rd_mux = {29'b0, overrun, busy, done};
            ADDR_CTRL:   rd_mux = {30'b0, lz_suppress, blank};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oData <= '0;
        end else if (rd_en) begin
            oData <= rd_mux;
        end
    end

    // Walk from the most significant digit so "all zero so far" marks leading zeros.
    logic lead_zero;
    always_comb begin
        oHEX      = '0;
        lead_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            lead_zero = lead_zero && (bcd[4*d +: 4] == 4'd0);
            if (blank || (lz_suppress && lead_zero && (d != 0))) begin
                oHEX[7*d +: 7] = 7'h7F;
            end else begin
                oHEX[7*d +: 7] = seg7(bcd[4*d +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_max_bcd_display.sv
// tb/tb_max_bcd_display.sv - scoreboard bench for max_bcd_display
// Stimulus queues expected results; a negedge monitor pops and compares them.
module tb_max_bcd_display;

    logic        iClk = 1'b0;
    logic        iReset_n;
    logic        iChipselect_n;
    logic        iWrite_n;
    logic        iRead_n;
    logic [1:0]  iAddress;
    logic [31:0] iData;
    logic [31:0] oData;
    logic [20:0] oHEX;

    always #5 iClk = ~iClk;

    max_bcd_display #(.DATA_W(7), .DIGITS(3)) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iChipselect_n (iChipselect_n),
        .iWrite_n      (iWrite_n),
        .iRead_n       (iRead_n),
        .iAddress      (iAddress),
        .iData         (iData),
        .oData         (oData),
        .oHEX          (oHEX)
    );

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t rd_q[$];
    chk_t now_q[$];
    chk_t mon_c;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic rd_seen;
    logic now_req = 1'b0;

    function automatic logic [31:0] hx(input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
        return {11'b0, d2, d1, d0};
    endfunction

    task automatic compare(input chk_t c, input logic [31:0] act);
        n_chk++;
        if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
    endtask

    always @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) rd_seen <= 1'b0;
        else           rd_seen <= !iChipselect_n && !iRead_n;
    end

    always @(negedge iClk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_read: got %h expected no read", oData);
            end else begin
                mon_c = rd_q.pop_front();
                compare(mon_c, oData);
            end
        end
        if (now_req && now_q.size() > 0) begin
            mon_c = now_q.pop_front();
            compare(mon_c, (mon_c.kind == 1) ? {11'b0, oHEX} : oData);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        iChipselect_n = 1'b0;
        iWrite_n      = 1'b0;
        iAddress      = a;
        iData         = d;
        @(posedge iClk);
        #1;
        iChipselect_n = 1'b1;
        iWrite_n      = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
        chk_t c;
        c.name = n; c.kind = 0; c.exp = e;
        rd_q.push_back(c);
        iChipselect_n = 1'b0;
        iRead_n       = 1'b0;
        iAddress      = a;
        @(posedge iClk);
        #1;
        iChipselect_n = 1'b1;
        iRead_n       = 1'b1;
    endtask

    task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
        chk_t c;
        c.name = n; c.kind = 0; c.exp = e;
        rd_q.push_back(c);
        iChipselect_n = 1'b0;
        iRead_n       = 1'b0;
        iWrite_n      = 1'b0;
        iAddress      = a;
        iData         = d;
        @(posedge iClk);
        #1;
        iChipselect_n = 1'b1;
        iRead_n       = 1'b1;
        iWrite_n      = 1'b1;
    endtask

    task automatic chk_now(input int kind, input logic [31:0] e, input string n);
        chk_t c;
        c.name = n; c.kind = kind; c.exp = e;
        now_q.push_back(c);
        now_req = 1'b1;
        @(negedge iClk);
        #1;
        now_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iReset_n      = 1'b0;
        iChipselect_n = 1'b1;
        iWrite_n      = 1'b1;
        iRead_n       = 1'b1;
        iAddress      = 2'd0;
        iData         = '0;
        repeat (2) @(posedge iClk);
        #1;
        iReset_n = 1'b1;
        idle(1);

        chk_now(1, hx(7'h40, 7'h40, 7'h40), "reset_hex");
        rd(2'd0, 32'h0, "reset_value");
        rd(2'd1, 32'h0, "reset_bcd");
        rd(2'd2, 32'h0, "reset_status");
        rd(2'd3, 32'h0, "reset_ctrl");

        // 127: busy for exactly 8 cycles, result lands on the 8th edge
        wr(2'd0, 32'd127);
        rd(2'd2, 32'h2, "t1_busy_first");
        idle(5);
        chk_now(1, hx(7'h40, 7'h40, 7'h40), "t1_hex_held_during_conv");
        rd(2'd2, 32'h2, "t1_busy_7");
        rd(2'd2, 32'h2, "t1_busy_8");
        rd(2'd2, 32'h1, "t1_done");
        chk_now(1, hx(7'h79, 7'h24, 7'h78), "t1_hex_127");
        rd(2'd1, 32'h127, "t1_bcd");

        // masking and leading-zero suppression
        wr(2'd3, 32'h2);
        wr(2'd0, 32'hFFFF_FF85);
        idle(9);
        rd(2'd0, 32'd5, "t2_value_masked");
        rd(2'd1, 32'h005, "t2_bcd");
        chk_now(1, hx(7'h7F, 7'h7F, 7'h12), "t2_hex_lz_5");
        wr(2'd0, 32'd40);
        idle(9);
        chk_now(1, hx(7'h7F, 7'h19, 7'h40), "t2_hex_lz_40");
        wr(2'd3, 32'h0);

        // overrun: second write dropped
        wr(2'd0, 32'd99);
        idle(2);
        wr(2'd0, 32'd42);
        idle(8);
        rd(2'd1, 32'h099, "t3_bcd");
        rd(2'd2, 32'h5, "t3_status_overrun");
        rd(2'd0, 32'd99, "t3_value_kept");
        chk_now(1, hx(7'h40, 7'h10, 7'h10), "t3_hex_099");
        wr(2'd2, 32'h5);
        rd(2'd2, 32'h0, "t3_status_cleared");

        // W1C on the same edge that sets done
        wr(2'd0, 32'd5);
        idle(7);
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h1, "w1c_vs_update_set_wins");

        // asynchronous reset mid-conversion
        wr(2'd0, 32'd100);
        rd(2'd0, 32'd100, "t4_value_before_reset");
        idle(2);
        iReset_n = 1'b0;
        chk_now(0, 32'h0, "t4_odata_reset");
        chk_now(1, hx(7'h40, 7'h40, 7'h40), "t4_hex_reset");
        idle(1);
        iReset_n = 1'b1;
        rd(2'd0, 32'h0, "t4_value_reset");
        rd(2'd1, 32'h0, "t4_bcd_reset");
        rd(2'd2, 32'h0, "t4_status_reset");
        wr(2'd0, 32'd64);
        idle(9);
        rd(2'd1, 32'h064, "t4_bcd_64");
        chk_now(1, hx(7'h40, 7'h02, 7'h19), "t4_hex_64");

        // blanking
        wr(2'd0, 32'd127);
        idle(9);
        wr(2'd3, 32'h1);
        chk_now(1, hx(7'h7F, 7'h7F, 7'h7F), "t5_hex_blank");
        rd(2'd3, 32'h1, "t5_ctrl_blank");
        wr(2'd3, 32'h0);
        chk_now(1, hx(7'h79, 7'h24, 7'h78), "t5_hex_restored");
        rd(2'd1, 32'h127, "t5_bcd_unchanged");

        // read and write VALUE on the same edge
        wr(2'd0, 32'd7);
        idle(9);
        rdwr(2'd0, 32'd10, 32'd7, "t6_read_old_value");
        rd(2'd2, 32'h2, "t6_done_cleared_busy");
        rd(2'd0, 32'd10, "t6_read_new_value");
        idle(9);
        rd(2'd1, 32'h010, "t6_bcd_10");

        idle(2);
        if (rd_q.size() != 0 || now_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", rd_q.size() + now_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
